cpu_alu: RTL and testbench

8-bit arithmetic/logic unit for the 6502-compatible CPU core. It performs add-with-carry, subtract-with-borrow, AND, OR, EOR and shift-right-through-carry on two byte operands. It produces a registered result plus carry, overflow, zero and sign flags, which the CPU controller uses for the accumulator and the P register. It sits beside the controller FSM and is driven by the `alu_a`/`alu_b` operand muxes and by a mode decoded from IR.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/alu_adder8.sv | 32 +++
 rtl/cpu_alu.sv | 118 +++++++++++
 tb/tb_cpu_alu.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package   : cpu_pkg
// Purpose   : Constants shared between the ALU and the CPU controller.
//             ALU mode encodings as decoded from IR by the controller.
// Revision  : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int unsigned ALU_MODE_W = 5;

  localparam logic [ALU_MODE_W-1:0] ALU_ADD = 5'd0;
  localparam logic [ALU_MODE_W-1:0] ALU_AND = 5'd1;
  localparam logic [ALU_MODE_W-1:0] ALU_OR  = 5'd2;
  localparam logic [ALU_MODE_W-1:0] ALU_EOR = 5'd3;
  localparam logic [ALU_MODE_W-1:0] ALU_SR  = 5'd4;
  localparam logic [ALU_MODE_W-1:0] ALU_SUB = 5'd5;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/alu_adder8.sv
`default_nettype none
// ============================================================================
// Module    : alu_adder8
// Purpose   : 8-bit ripple adder with carry-in, carry-out and signed overflow.
//             Shared by ADD and SUB; the caller inverts b for subtraction.
// Ports     : a, b    - byte operands (b already inverted for SUB)
//             cin     - carry in
//             sum     - low 8 bits of a + b + cin
//             cout    - bit 8 of the sum
//             v       - two's-complement overflow
// Revision  : 1.0 - initial release
// ============================================================================
module alu_adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       v
);

  logic [8:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b} + {8'h00, cin};
  assign sum      = full_sum[7:0];
  assign cout     = full_sum[8];
  // Overflow when both addends share a sign and the result sign differs.
  // With b inverted for SUB this becomes the a[7]!=b[7] subtract rule.
  assign v        = (a[7] == b[7]) && (full_sum[7] != a[7]);

endmodule : alu_adder8
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module    : cpu_alu
// Purpose   : 8-bit ALU for the 6502-compatible core. ADD/SUB/AND/OR/EOR and
//             shift-right-through-carry, with registered result and C/V/Z/N.
// Ports     : clk       - clock, outputs update on rising edge
//             reset     - asynchronous active-low reset, clears all outputs
//             alu_a     - operand A / shift source
//             alu_b     - operand B
//             mode      - operation select (cpu_pkg ALU_* encodings)
//             carry_in  - carry into ADD/SUB, fill bit for SR
//             alu_out   - result
//             carry_out - carry / no-borrow / shifted-out bit
//             overflow  - signed overflow (V)
//             zero      - result == 0 (Z)
//             sign      - result bit 7 (N)
// Revision  : 1.0 - initial release
// ============================================================================
module cpu_alu
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            alu_a,
  input  logic [7:0]            alu_b,
  input  logic [ALU_MODE_W-1:0] mode,
  input  logic                  carry_in,
  output logic [7:0]            alu_out,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  zero,
  output logic                  sign
);

  logic [7:0] add_b;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       add_v;

  logic [7:0] out_d,   out_q;
  logic       carry_d, carry_q;
  logic       ovf_d,   ovf_q;
  logic       zero_d,  zero_q;
  logic       sign_d,  sign_q;

  // 6502 subtract is a + ~b + C, so SUB reuses the adder with b inverted.
  assign add_b = (mode == ALU_SUB) ? ~alu_b : alu_b;

  alu_adder8 u_adder (
    .a    (alu_a),
    .b    (add_b),
    .cin  (carry_in),
    .sum  (add_sum),
    .cout (add_cout),
    .v    (add_v)
  );

  always_comb begin
    out_d   = 8'h00;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (mode)
      ALU_ADD, ALU_SUB: begin
        out_d   = add_sum;
        carry_d = add_cout;
        ovf_d   = add_v;
      end
      ALU_AND: begin
        out_d   = alu_a & alu_b;
        carry_d = carry_in;
      end
      ALU_OR: begin
        out_d   = alu_a | alu_b;
        carry_d = carry_in;
      end
      ALU_EOR: begin
        out_d   = alu_a ^ alu_b;
        carry_d = carry_in;
      end
      ALU_SR: begin
        out_d   = {carry_in, alu_a[7:1]};
        carry_d = alu_a[0];
      end
      default: begin
        // Unused modes yield 0x00 with C=V=0.
        out_d   = 8'h00;
        carry_d = 1'b0;
      end
    endcase
    zero_d = (out_d == 8'h00);
    sign_d = out_d[7];
  end

  // zero clears to 0 in reset rather than reflecting the cleared result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= 8'h00;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      sign_q  <= sign_d;
    end
  end

  assign alu_out   = out_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign sign      = sign_q;

endmodule : cpu_alu
`default_nettype wire

// File: tb/tb_cpu_alu.sv
`default_nettype none
// ============================================================================
// Module    : tb_cpu_alu
// Purpose   : Self-checking bench for cpu_alu. Expected {out,C,V,Z,N} words
//             are queued when an operation is driven and popped one edge
//             later when the registered result appears.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_cpu_alu;

  logic       clk;
  logic       reset;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [4:0] mode;
  logic       carry_in;
  logic [7:0] alu_out;
  logic       carry_out;
  logic       overflow;
  logic       zero;
  logic       sign;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [4:0]  m;
    logic        ci;
    logic [11:0] exp;
    string       name;
  } op_t;

  sb_t sb_q[$];

  cpu_alu dut (
    .clk       (clk),
    .reset     (reset),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .mode      (mode),
    .carry_in  (carry_in),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .sign      (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] observed();
    return {alu_out, carry_out, overflow, zero, sign};
  endfunction

  // Reference model written in plain integer arithmetic.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [4:0] m, input logic ci);
    int s, sv, sa, sb, c;
    logic [7:0] o;
    logic cf, vf;
    sa = int'($signed(a));
    sb = int'($signed(b));
    c  = ci ? 1 : 0;
    o  = 8'h00; cf = 1'b0; vf = 1'b0;
    case (m)
      5'd0: begin
        s  = int'(a) + int'(b) + c;
        o  = s[7:0];
        cf = (s > 255);
        sv = sa + sb + c;
        vf = (sv > 127) || (sv < -128);
      end
      5'd5: begin
        s  = int'(a) - int'(b) - (1 - c);
        o  = s[7:0];
        cf = (s >= 0);
        sv = sa - sb - (1 - c);
        vf = (sv > 127) || (sv < -128);
      end
      5'd1: begin o = a & b; cf = ci; end
      5'd2: begin o = a | b; cf = ci; end
      5'd3: begin o = a ^ b; cf = ci; end
      5'd4: begin o = (a >> 1) | (ci ? 8'h80 : 8'h00); cf = a[0]; end
      default: begin o = 8'h00; cf = 1'b0; end
    endcase
    return {o, cf, vf, (o == 8'h00), o[7]};
  endfunction

  task automatic drive(input op_t op);
    alu_a    = op.a;
    alu_b    = op.b;
    mode     = op.m;
    carry_in = op.ci;
    sb_q.push_back('{exp: op.exp, name: op.name});
  endtask

  task automatic test_reset();
    reset = 1'b0;
    alu_a = 8'h50; alu_b = 8'h50; mode = 5'd0; carry_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observed() !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", observed(), 12'h000);
    end
    @(negedge clk);
    reset = 1'b1;
    drive('{a: 8'h01, b: 8'h01, m: 5'd0, ci: 1'b0, exp: {8'h02, 4'b0000}, name: "first_add"});
    @(posedge clk);
    #1;
    begin
      sb_t e;
      e = sb_q.pop_front();
      checks++;
      if (observed() !== e.exp) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, observed(), e.exp);
      end
    end
  endtask

  task automatic test_vectors(input string tag, input op_t ops[$]);
    foreach (ops[i]) begin
      sb_t e;
      @(negedge clk);
      drive(ops[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (observed() !== e.exp) begin
        errors++;
        $display("FAIL %s/%s got=%h exp=%h", tag, e.name, observed(), e.exp);
      end
    end
  endtask

  task automatic test_add();
    op_t ops[$];
    ops.push_back('{8'h50, 8'h50, 5'd0, 1'b0, {8'hA0, 4'b0101}, "add_ovf"});
    ops.push_back('{8'hFF, 8'h01, 5'd0, 1'b0, {8'h00, 4'b1010}, "add_carry"});
    ops.push_back('{8'hFF, 8'h00, 5'd0, 1'b1, {8'h00, 4'b1010}, "add_cin"});
    test_vectors("add", ops);
  endtask

  task automatic test_sub();
    op_t ops[$];
    ops.push_back('{8'h05, 8'h05, 5'd5, 1'b1, {8'h00, 4'b1010}, "sub_eq"});
    ops.push_back('{8'h50, 8'hB0, 5'd5, 1'b1, {8'hA0, 4'b0101}, "sub_ovf"});
    ops.push_back('{8'h00, 8'h00, 5'd5, 1'b0, {8'hFF, 4'b0001}, "sub_borrow"});
    test_vectors("sub", ops);
  endtask

  task automatic test_logic();
    op_t ops[$];
    ops.push_back('{8'hF0, 8'h3C, 5'd1, 1'b0, {8'h30, 4'b0000}, "and_c0"});
    ops.push_back('{8'hF0, 8'h3C, 5'd1, 1'b1, {8'h30, 4'b1000}, "and_c1"});
    ops.push_back('{8'hF0, 8'h0C, 5'd2, 1'b0, {8'hFC, 4'b0001}, "or_c0"});
    ops.push_back('{8'hF0, 8'h0C, 5'd2, 1'b1, {8'hFC, 4'b1001}, "or_c1"});
    ops.push_back('{8'hFF, 8'hFF, 5'd3, 1'b0, {8'h00, 4'b0010}, "eor_c0"});
    ops.push_back('{8'hFF, 8'hFF, 5'd3, 1'b1, {8'h00, 4'b1010}, "eor_c1"});
    test_vectors("logic", ops);
  endtask

  task automatic test_sr();
    op_t ops[$];
    ops.push_back('{8'h81, 8'h00, 5'd4, 1'b0, {8'h40, 4'b1000}, "lsr"});
    ops.push_back('{8'h81, 8'h00, 5'd4, 1'b1, {8'hC0, 4'b1001}, "ror"});
    ops.push_back('{8'h01, 8'hFF, 5'd4, 1'b0, {8'h00, 4'b1010}, "sr_zero"});
    test_vectors("sr", ops);
  endtask

  task automatic test_unused();
    op_t ops[$];
    ops.push_back('{8'hFF, 8'hFF, 5'd7,  1'b1, {8'h00, 4'b0010}, "mode7"});
    ops.push_back('{8'hFF, 8'hFF, 5'd6,  1'b1, {8'h00, 4'b0010}, "mode6"});
    ops.push_back('{8'h12, 8'h34, 5'd31, 1'b1, {8'h00, 4'b0010}, "mode31"});
    test_vectors("unused", ops);
  endtask

  task automatic test_back_to_back();
    op_t op;
    for (int i = 0; i < 60; i++) begin
      sb_t e;
      @(negedge clk);
      op.a  = 8'($urandom);
      op.b  = 8'($urandom);
      op.m  = 5'($urandom_range(0, 7));
      op.ci = 1'($urandom);
      op.exp  = model(op.a, op.b, op.m, op.ci);
      op.name = $sformatf("b2b%0d_m%0d_%h_%h_%0d", i, op.m, op.a, op.b, op.ci);
      drive(op);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (observed() !== e.exp) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, observed(), e.exp);
      end
      // Input changes between edges must not disturb the held result.
      alu_a = ~alu_a; alu_b = ~alu_b; carry_in = ~carry_in;
      #2;
      checks++;
      if (observed() !== e.exp) begin
        errors++;
        $display("FAIL hold_%s got=%h exp=%h", e.name, observed(), e.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    sb_t e;
    @(negedge clk);
    drive('{a: 8'h50, b: 8'h50, m: 5'd0, ci: 1'b0, exp: {8'hA0, 4'b0101}, name: "pre_reset"});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (observed() !== e.exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", e.name, observed(), e.exp);
    end
    // Assert reset mid-cycle and look well before the next rising edge.
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (observed() !== 12'h000) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", observed(), 12'h000);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_sr();
    test_unused();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cpu_alu
`default_nettype wire
